spi_reg_ctrl: RTL and testbench

SPI_REG_CTRL -- requirements
Module: spi_reg_ctrl

---
 rtl/spi_reg_ctrl_pkg.sv | 20 ++
 rtl/spi_reg_ctrl_sync_ff.sv | 25 ++
 rtl/spi_reg_ctrl.sv | 121 ++++++++++++
 tb/tb_spi_reg_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/spi_reg_ctrl_pkg.sv
// Shared constants and types for the SPI-driven configuration register block.
package spi_reg_ctrl_pkg;

  localparam int FRAME_W = 16;

  localparam logic [6:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [6:0] ADDR_DUTY      = 7'h04;

  localparam logic [4:0] BITCNT_SAT = 5'd17;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

endpackage

// File: rtl/spi_reg_ctrl_sync_ff.sv
// Multi-flop synchronizer for one asynchronous input bit, with a selectable idle level.
module sync_ff #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
    end else begin
      sync_q[0] <= d_i;
      for (int i = 1; i < STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_reg_ctrl.sv
// SPI write-only register target: 16-bit frames (R/W, 7-bit addr, 8-bit data) into five config registers.
module spi_reg_ctrl
  import spi_reg_ctrl_pkg::*;
#(
  parameter int         SYNC_STAGES = 2,
  parameter logic [6:0] MAX_ADDR    = 7'h04
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       sclk,
  input  logic       copi,
  input  logic       ncs,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       cfg_update,
  output logic       frame_err
);

  logic sclk_s, copi_s, ncs_s;

  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .rst_n(rst_n), .d_i(sclk), .q_o(sclk_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (.clk(clk), .rst_n(rst_n), .d_i(copi), .q_o(copi_s));
  sync_ff #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs  (.clk(clk), .rst_n(rst_n), .d_i(ncs),  .q_o(ncs_s));

  state_e                  state_q, state_d;
  logic [FRAME_W-1:0]      shift_q, shift_d;
  logic [4:0]              cnt_q, cnt_d;
  logic [4:0][7:0]         reg_q, reg_d;
  logic                    err_q, err_d;
  logic                    sclk_d_q, ncs_d_q;
  logic [SYNC_STAGES:0]    flush_q;
  logic                    sclk_rise, ncs_rise, ncs_fall, armed;
  logic                    wr_en;
  logic [6:0]              addr;

  assign sclk_rise = sclk_s & ~sclk_d_q;
  assign ncs_rise  = ncs_s & ~ncs_d_q;
  assign ncs_fall  = ~ncs_s & ncs_d_q;
  // After reset the chains still hold idle levels; a chip select already low at
  // release would look like a fresh falling edge, so edges are ignored until flushed.
  assign armed     = flush_q[SYNC_STAGES];
  assign addr      = shift_q[14:8];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      reg_q    <= '0;
      err_q    <= 1'b0;
      sclk_d_q <= 1'b0;
      ncs_d_q  <= 1'b1;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      reg_q    <= reg_d;
      err_q    <= err_d;
      sclk_d_q <= sclk_s;
      ncs_d_q  <= ncs_s;
      flush_q  <= {flush_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    cnt_d   = cnt_q;
    reg_d   = reg_q;
    err_d   = err_q;
    wr_en   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (ncs_fall && armed) begin
          state_d = ST_SHIFT;
          shift_d = '0;
          cnt_d   = '0;
        end
      end
      ST_SHIFT: begin
        // ncs rise wins over a coincident sclk rise: that last edge is dropped
        if (ncs_rise) begin
          state_d = ST_COMMIT;
        end else if (sclk_rise) begin
          shift_d = {shift_q[FRAME_W-2:0], copi_s};
          if (cnt_q != BITCNT_SAT) cnt_d = cnt_q + 5'd1;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (cnt_q != 5'(FRAME_W)) begin
          err_d = 1'b1;
        end else if (shift_q[15] && addr <= MAX_ADDR) begin
          wr_en = 1'b1;
          case (addr)
            ADDR_EN_OUT_LO: reg_d[0] = shift_q[7:0];
            ADDR_EN_OUT_HI: reg_d[1] = shift_q[7:0];
            ADDR_EN_PWM_LO: reg_d[2] = shift_q[7:0];
            ADDR_EN_PWM_HI: reg_d[3] = shift_q[7:0];
            ADDR_DUTY:      reg_d[4] = shift_q[7:0];
            default:        wr_en    = 1'b0;
          endcase
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign en_reg_out_7_0  = reg_q[0];
  assign en_reg_out_15_8 = reg_q[1];
  assign en_reg_pwm_7_0  = reg_q[2];
  assign en_reg_pwm_15_8 = reg_q[3];
  assign pwm_duty_cycle  = reg_q[4];
  assign cfg_update      = wr_en;
  assign frame_err       = err_q;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Self-checking bench: directed frame table, reset-abort sequence, then random frames against a decode model.
module tb_spi_reg_ctrl;

  localparam int SYNC_STAGES = 2;
  localparam int HALF        = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic       ncs = 1'b1;
  logic [7:0] out_lo, out_hi, pwm_lo, pwm_hi, duty;
  logic       cfg_update, frame_err;

  spi_reg_ctrl #(.SYNC_STAGES(SYNC_STAGES), .MAX_ADDR(7'h04)) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .copi(copi), .ncs(ncs),
    .en_reg_out_7_0(out_lo), .en_reg_out_15_8(out_hi),
    .en_reg_pwm_7_0(pwm_lo), .en_reg_pwm_15_8(pwm_hi),
    .pwm_duty_cycle(duty), .cfg_update(cfg_update), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cfg_cnt = 0;

  always @(negedge clk) if (cfg_update === 1'b1) cfg_cnt++;

  // reference model: register file contents and sticky error flag
  logic [7:0] m_reg [5];
  logic       m_err;

  typedef struct {
    logic [16:0]     val;
    int              n;
    logic [4:0][7:0] e_reg;   // index 0 = addr 0x00
    logic            e_err;
    int              e_pulse;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] dut_reg(input int i);
    case (i)
      0: return out_lo;
      1: return out_hi;
      2: return pwm_lo;
      3: return pwm_hi;
      default: return duty;
    endcase
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 5; i++) m_reg[i] = 8'h00;
    m_err = 1'b0;
  endtask

  // Frame semantics straight from the frame definition: only a well-formed
  // 16-bit write to an existing address changes state.
  task automatic model_apply(input logic [16:0] val, input int n, output bit wr);
    int a;
    wr = 1'b0;
    if (n != 16) begin
      m_err = 1'b1;
    end else begin
      a = int'(val[14:8]);
      if (val[15] && a <= 4) begin
        m_reg[a] = val[7:0];
        wr = 1'b1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    for (int i = 0; i < 5; i++) chk($sformatf("%s reg%0d", tag, i), int'(dut_reg(i)), int'(m_reg[i]));
    chk({tag, " frame_err"}, int'(frame_err), int'(m_err));
  endtask

  // Clocks n bits of val (MSB first) then raises ncs on a negedge and checks
  // the commit timing: outputs old + cfg_update at edge k+S, new at k+S+1.
  task automatic send_frame(input logic [16:0] val, input int n, input string tag, output int pulses);
    logic [7:0] pre [5];
    bit wr;
    int c0;
    for (int i = 0; i < 5; i++) pre[i] = m_reg[i];
    model_apply(val, n, wr);
    ncs = 1'b0;
    wait_clk(HALF);
    for (int i = n - 1; i >= 0; i--) begin
      copi = val[i];
      wait_clk(HALF);
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
    wait_clk(HALF);
    c0 = cfg_cnt;
    ncs = 1'b1;
    repeat (SYNC_STAGES + 1) @(posedge clk);
    #1;
    chk({tag, " cfg_update@commit"}, int'(cfg_update), int'(wr));
    for (int i = 0; i < 5; i++) chk($sformatf("%s reg%0d@commit", tag, i), int'(dut_reg(i)), int'(pre[i]));
    @(posedge clk);
    #1;
    chk({tag, " cfg_update after"}, int'(cfg_update), 0);
    check_model(tag);
    wait_clk(SYNC_STAGES + 4);
    pulses = cfg_cnt - c0;
    chk({tag, " pulses"}, pulses, int'(wr));
  endtask

  initial begin
    int p;
    logic [16:0] v;
    int n;

    vecs[0] = '{17'h080F0, 16, {8'h00, 8'h00, 8'h00, 8'h00, 8'hF0}, 1'b0, 1};
    vecs[1] = '{17'h08480, 16, {8'h80, 8'h00, 8'h00, 8'h00, 8'hF0}, 1'b0, 1};
    vecs[2] = '{17'h084FF, 16, {8'hFF, 8'h00, 8'h00, 8'h00, 8'hF0}, 1'b0, 1};
    vecs[3] = '{17'h00255, 16, {8'hFF, 8'h00, 8'h00, 8'h00, 8'hF0}, 1'b0, 0};
    vecs[4] = '{17'h085AA, 16, {8'hFF, 8'h00, 8'h00, 8'h00, 8'hF0}, 1'b0, 0};
    vecs[5] = '{17'h0412D, 15, {8'hFF, 8'h00, 8'h00, 8'h00, 8'hF0}, 1'b1, 0};
    vecs[6] = '{17'h104B5, 17, {8'hFF, 8'h00, 8'h00, 8'h00, 8'hF0}, 1'b1, 0};

    model_reset();
    wait_clk(3);
    for (int i = 0; i < 5; i++) chk($sformatf("reset reg%0d", i), int'(dut_reg(i)), 0);
    chk("reset frame_err", int'(frame_err), 0);
    chk("reset cfg_update", int'(cfg_update), 0);
    rst_n = 1'b1;
    wait_clk(6);

    for (int k = 0; k < 7; k++) begin
      send_frame(vecs[k].val, vecs[k].n, $sformatf("vec%0d", k), p);
      for (int i = 0; i < 5; i++)
        chk($sformatf("vec%0d table reg%0d", k, i), int'(dut_reg(i)), int'(vecs[k].e_reg[i]));
      chk($sformatf("vec%0d table err", k), int'(frame_err), int'(vecs[k].e_err));
      chk($sformatf("vec%0d table pulses", k), p, vecs[k].e_pulse);
    end

    // reset pulsed after 8 bits of a write to 0x03; the tail of that frame must not land
    v = 17'h083A5;
    ncs = 1'b0;
    wait_clk(HALF);
    for (int i = 15; i >= 8; i--) begin
      copi = v[i];
      wait_clk(HALF);
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 5; i++) chk($sformatf("midreset reg%0d", i), int'(dut_reg(i)), 0);
    chk("midreset frame_err", int'(frame_err), 0);
    model_reset();
    wait_clk(3);
    rst_n = 1'b1;
    p = cfg_cnt;
    for (int i = 7; i >= 0; i--) begin
      copi = v[i];
      wait_clk(HALF);
      sclk = 1'b1;
      wait_clk(HALF);
      sclk = 1'b0;
    end
    wait_clk(HALF);
    ncs = 1'b1;
    wait_clk(SYNC_STAGES + 6);
    check_model("abort tail");
    chk("abort tail pulses", cfg_cnt - p, 0);
    send_frame(17'h0833C, 16, "post-reset", p);
    chk("post-reset pwm_hi", int'(pwm_hi), 8'h3C);

    for (int k = 0; k < 24; k++) begin
      n = 16;
      case ($urandom_range(0, 9))
        0: n = 15;
        1: n = 17;
        default: n = 16;
      endcase
      v = 17'($urandom);
      if (n == 16) begin
        v[16] = 1'b0;
        v[15] = ($urandom_range(0, 3) != 0);
        v[14:8] = 7'($urandom_range(0, 7));
      end
      send_frame(v, n, $sformatf("rnd%0d", k), p);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
